// File: rtl/link_pkg.sv
// Shared definitions for the four-phase req/ack byte link (master, slave and responder ends).
package link_pkg;

  localparam int LINK_DATA_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } link_state_e;

endpackage

// File: rtl/link_rx_fifo.sv
// First-word-fall-through synchronous FIFO for the link responder.
// Full/empty come from the pre-edge count, so a pop never frees room for a same-edge push when full.
module link_rx_fifo
  import link_pkg::*;
#(
  parameter int DATA_W = LINK_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic              do_push, do_pop;

  assign full    = (count_q == CNT_MAX);
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/link_rx_responder.sv
// Responder end of the req/ack byte link: buffers accepted bytes into a FWFT FIFO with byte count and done.
// Define LINK_PARITY_EN to add the par input and sticky par_err output (even parity over {par,data}).
module link_rx_responder
  import link_pkg::*;
#(
  parameter int DATA_W       = LINK_DATA_W,
  parameter int DEPTH        = 4,
  parameter int EXPECT_BYTES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [DATA_W-1:0] data,
`ifdef LINK_PARITY_EN
  input  logic              par,
  output logic              par_err,
`endif
  output logic              ack,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [DATA_W-1:0] last_byte,
  output logic [15:0]       byte_count,
  output logic              done
);

  localparam logic [15:0] EXP_CNT = 16'(EXPECT_BYTES);

  link_state_e       state_q, state_d;
  logic              push, par_ok, fifo_full, fifo_empty;
  logic [DATA_W-1:0] last_byte_q;
  logic [15:0]       byte_count_q, byte_count_d;
  logic              done_q;

`ifdef LINK_PARITY_EN
  logic par_err_q;
  assign par_ok  = ~^{par, data};
  assign par_err = par_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) par_err_q <= 1'b0;
    else if (state_q == IDLE && req && !par_ok) par_err_q <= 1'b1;
  end
`else
  assign par_ok = 1'b1;
`endif

  // A parity-failed byte is still handshaken so the master is not stalled, it just is not stored.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (!par_ok) begin
            state_d = ACK;
          end else if (!fifo_full) begin
            push    = 1'b1;
            state_d = ACK;
          end
        end
      end
      ACK: begin
        if (!req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_count_d = (byte_count_q == 16'hFFFF) ? byte_count_q : byte_count_q + 16'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_byte_q  <= '0;
      byte_count_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) begin
        last_byte_q  <= data;
        byte_count_q <= byte_count_d;
        if (EXPECT_BYTES != 0 && byte_count_d == EXP_CNT) done_q <= 1'b1;
      end
    end
  end

  link_rx_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(data),
    .pop      (out_ready),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (out_data)
  );

  assign ack        = (state_q == ACK);
  assign out_valid  = ~fifo_empty;
  assign last_byte  = last_byte_q;
  assign byte_count = byte_count_q;
  assign done       = done_q;

endmodule

// File: tb/tb_link_rx_responder.sv
// Self-checking bench for link_rx_responder: directed table, hand sequences and a randomized run against a queue model.
module tb_link_rx_responder;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int EXPB  = 8;

  logic          clk = 1'b0;
  logic          rst, req, out_ready;
  logic [DW-1:0] data;
  logic          ack, out_valid, done;
  logic [DW-1:0] out_data, last_byte;
  logic [15:0]   byte_count;
`ifdef LINK_PARITY_EN
  logic          par, par_err;
`endif

  always #5 clk = ~clk;

  link_rx_responder #(.DATA_W(DW), .DEPTH(DEPTH), .EXPECT_BYTES(EXPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data      (data),
`ifdef LINK_PARITY_EN
    .par       (par),
    .par_err   (par_err),
`endif
    .ack       (ack),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .last_byte (last_byte),
    .byte_count(byte_count),
    .done      (done)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: a byte queue plus "master is mid-handshake" flag.
  logic [DW-1:0] mq[$];
  bit            m_hs;
  int            m_cnt;
  logic [DW-1:0] m_last;
  bit            m_done, m_perr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_hs   = 0;
    m_cnt  = 0;
    m_last = '0;
    m_done = 0;
    m_perr = 0;
  endtask

  task automatic model_edge();
    bit was_full, pok;
    was_full = (mq.size() == DEPTH);
    pok      = 1;
`ifdef LINK_PARITY_EN
    pok = ((^{par, data}) == 1'b0);
`endif
    if (out_ready && mq.size() > 0) void'(mq.pop_front());
    if (!m_hs) begin
      if (req) begin
        if (!pok) begin
          m_hs   = 1;
          m_perr = 1;
        end else if (!was_full) begin
          mq.push_back(data);
          m_last = data;
          if (m_cnt < 65535) m_cnt++;
          if (EXPB != 0 && m_cnt == EXPB) m_done = 1;
          m_hs = 1;
        end
      end
    end else if (!req) begin
      m_hs = 0;
    end
  endtask

  task automatic check_model();
    chk("ack", 32'(ack), 32'(m_hs));
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("byte_count", 32'(byte_count), 32'(m_cnt));
    chk("last_byte", 32'(last_byte), 32'(m_last));
    chk("done", 32'(done), 32'(m_done));
    if (mq.size() > 0) chk("out_data", 32'(out_data), 32'(mq[0]));
`ifdef LINK_PARITY_EN
    chk("par_err", 32'(par_err), 32'(m_perr));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without waiting for a clock.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_last", 32'(last_byte), 32'd0);
    chk("rst_count", 32'(byte_count), 32'd0);
    model_reset();
    req       = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic          req;
    logic [DW-1:0] d;
    logic          rdy;
    logic          e_ack;
    logic          e_v;
    logic [DW-1:0] e_data;
    logic [15:0]   e_cnt;
  } vec_t;

  vec_t tbl[16];

  initial begin
    rst = 1'b1; req = 1'b0; data = '0; out_ready = 1'b0;
`ifdef LINK_PARITY_EN
    par = 1'b0;
`endif
    //         req  d      rdy  ack  v    data   cnt
    tbl[0]  = '{1, 8'hA5, 0,   1,   1,   8'hA5, 16'd1};
    tbl[1]  = '{0, 8'hA5, 0,   0,   1,   8'hA5, 16'd1};
    tbl[2]  = '{0, 8'h00, 1,   0,   0,   8'h00, 16'd1};
    tbl[3]  = '{1, 8'h10, 0,   1,   1,   8'h10, 16'd2};
    tbl[4]  = '{1, 8'h10, 0,   1,   1,   8'h10, 16'd2};
    tbl[5]  = '{0, 8'h10, 0,   0,   1,   8'h10, 16'd2};
    tbl[6]  = '{1, 8'h11, 0,   1,   1,   8'h10, 16'd3};
    tbl[7]  = '{0, 8'h11, 0,   0,   1,   8'h10, 16'd3};
    tbl[8]  = '{1, 8'h12, 0,   1,   1,   8'h10, 16'd4};
    tbl[9]  = '{0, 8'h12, 0,   0,   1,   8'h10, 16'd4};
    tbl[10] = '{1, 8'h13, 0,   1,   1,   8'h10, 16'd5};
    tbl[11] = '{0, 8'h13, 0,   0,   1,   8'h10, 16'd5};
    tbl[12] = '{1, 8'h14, 0,   0,   1,   8'h10, 16'd5};
    tbl[13] = '{1, 8'h14, 1,   0,   1,   8'h11, 16'd5};
    tbl[14] = '{1, 8'h14, 0,   1,   1,   8'h11, 16'd6};
    tbl[15] = '{0, 8'h14, 0,   0,   1,   8'h11, 16'd6};

    do_reset();

    // Single byte handshake, then fill to full and the blocked-push-on-pop corner.
    for (int i = 0; i < 16; i++) begin
      req = tbl[i].req; data = tbl[i].d; out_ready = tbl[i].rdy;
`ifdef LINK_PARITY_EN
      par = ^tbl[i].d;
`endif
      tick();
      chk($sformatf("tbl%0d_ack", i), 32'(ack), 32'(tbl[i].e_ack));
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_v));
      chk($sformatf("tbl%0d_count", i), 32'(byte_count), 32'(tbl[i].e_cnt));
      if (tbl[i].e_v) chk($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].e_data));
    end

    // Stream 00..08 with downstream always ready; done rises on the 8th byte and stays.
    do_reset();
    for (int b = 0; b < 9; b++) begin
      req = 1'b1; data = DW'(b); out_ready = 1'b1;
`ifdef LINK_PARITY_EN
      par = ^data;
`endif
      tick();
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_data", 32'(out_data), 32'(b));
      chk("stream_last", 32'(last_byte), 32'(b));
      chk("stream_done", 32'(done), 32'(b >= 7));
      req = 1'b0;
      tick();
      chk("stream_drain", 32'(out_valid), 32'd0);
    end

    // Reset while in the ACK phase with two bytes buffered.
    do_reset();
    req = 1'b1; data = 8'h21;
`ifdef LINK_PARITY_EN
    par = ^data;
`endif
    tick();
    req = 1'b0;
    tick();
    req = 1'b1; data = 8'h22;
`ifdef LINK_PARITY_EN
    par = ^data;
`endif
    tick();
    chk("pre_rst_ack", 32'(ack), 32'd1);
    chk("pre_rst_count", 32'(byte_count), 32'd2);
    do_reset();
    tick();
    req = 1'b1; data = 8'h5A;
`ifdef LINK_PARITY_EN
    par = ^data;
`endif
    tick();
    chk("post_rst_ack", 32'(ack), 32'd1);
    chk("post_rst_data", 32'(out_data), 32'h5A);
    chk("post_rst_count", 32'(byte_count), 32'd1);
    req = 1'b0;
    tick();

`ifdef LINK_PARITY_EN
    do_reset();
    req = 1'b1; data = 8'h03; par = 1'b1;
    tick();
    chk("par_bad_ack", 32'(ack), 32'd1);
    chk("par_bad_valid", 32'(out_valid), 32'd0);
    chk("par_bad_err", 32'(par_err), 32'd1);
    chk("par_bad_count", 32'(byte_count), 32'd0);
    req = 1'b0;
    tick();
    req = 1'b1; data = 8'h03; par = 1'b0;
    tick();
    chk("par_ok_valid", 32'(out_valid), 32'd1);
    chk("par_ok_data", 32'(out_data), 32'h03);
    chk("par_ok_count", 32'(byte_count), 32'd1);
    req = 1'b0;
    tick();
`endif

    // Randomized traffic against the model with varying downstream backpressure.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (req && ack) begin
        if ($urandom_range(0, 3) != 0) req = 1'b0;
      end else if (!req) begin
        if ($urandom_range(0, 2) == 0) begin
          req  = 1'b1;
          data = DW'($urandom);
`ifdef LINK_PARITY_EN
          par = (^data) ^ ($urandom_range(0, 7) == 0);
`endif
        end
      end
      out_ready = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
